// File: rtl/hmac_ctrl_pkg.sv
// Shared constants, address map, FSM state type and STATUS layout for the HMAC control wrapper.
package hmac_ctrl_pkg;

    localparam int unsigned WORD_WIDTH = 32;

    // Register offsets
    localparam logic [31:0] ADDR_NAME0      = 32'h0000_0000;
    localparam logic [31:0] ADDR_NAME1      = 32'h0000_0004;
    localparam logic [31:0] ADDR_VERSION0   = 32'h0000_0008;
    localparam logic [31:0] ADDR_VERSION1   = 32'h0000_000C;
    localparam logic [31:0] ADDR_CTRL       = 32'h0000_0010;
    localparam logic [31:0] ADDR_STATUS     = 32'h0000_0018;
    localparam logic [31:0] ADDR_INTR       = 32'h0000_001C;
    localparam logic [31:0] ADDR_KEY_BASE   = 32'h0000_0040;
    localparam logic [31:0] ADDR_BLOCK_BASE = 32'h0000_0080;
    localparam logic [31:0] ADDR_TAG_BASE   = 32'h0000_0100;

    // Window sizes in words (upper bound of each bank parameter)
    localparam int unsigned KEY_WORDS_MAX   = 16;
    localparam int unsigned BLOCK_WORDS_MAX = 32;
    localparam int unsigned TAG_WORDS_MAX   = 16;
    localparam int unsigned TAG384_WORDS    = 12;

    // CTRL bit positions
    localparam int unsigned CTRL_INIT_BIT    = 0;
    localparam int unsigned CTRL_NEXT_BIT    = 1;
    localparam int unsigned CTRL_ZEROIZE_BIT = 2;
    localparam int unsigned CTRL_MODE_BIT    = 3;

    // INTR bit positions
    localparam int unsigned INTR_EN_BIT      = 0;
    localparam int unsigned INTR_DONE_BIT    = 1;
    localparam int unsigned INTR_ERR_CMD_BIT = 2;
    localparam int unsigned INTR_ERR_WR_BIT  = 3;

    // Identification constants ("hmac", "ctrl", version 2.0)
    localparam logic [31:0] NAME0_VALUE    = 32'h686D_6163;
    localparam logic [31:0] NAME1_VALUE    = 32'h6374_726C;
    localparam logic [31:0] VERSION0_VALUE = 32'h0000_0200;
    localparam logic [31:0] VERSION1_VALUE = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_CAPTURE = 2'd3
    } fsm_state_e;

    typedef struct packed {
        logic [26:0] rsvd;
        logic        err_wr;
        logic        err_cmd;
        logic        done;
        logic        tag_valid;
        logic        ready;
    } status_t;

    // True when addr is a word-aligned address inside a bank window
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                       input int unsigned words);
        return (addr >= base) && (addr < (base + 32'(words * 4))) && (addr[1:0] == 2'b00);
    endfunction

    // Word index of addr relative to a bank base
    function automatic logic [4:0] word_index(input logic [31:0] addr, input logic [31:0] base);
        return 5'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/hmac_ctrl_fsm.sv
// Command sequencer: accepts init/next in IDLE, pulses the core and strobes tag capture.
module hmac_ctrl_fsm
    import hmac_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ctrl_wr,
    input  logic       init_bit,
    input  logic       next_bit,
    input  logic       zeroize_bit,
    input  logic       ready_q,
    input  logic       tag_rise,
    output fsm_state_e state,
    output logic       core_init,
    output logic       core_next,
    output logic       capture,
    output logic       accept_init_c,
    output logic       reject_c
);

    logic req_c;
    logic go_c;

    // Zeroize shadows any command written alongside it
    assign req_c         = ctrl_wr & (init_bit | next_bit) & ~zeroize_bit;
    assign go_c          = req_c & (state == ST_IDLE) & ready_q;
    assign accept_init_c = go_c & init_bit;
    assign reject_c      = req_c & ~go_c;

    // State register with registered one-cycle command pulses and capture strobe
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            core_init <= 1'b0;
            core_next <= 1'b0;
            capture   <= 1'b0;
        end else begin
            core_init <= 1'b0;
            core_next <= 1'b0;
            capture   <= 1'b0;
            if (ctrl_wr && zeroize_bit) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (go_c) begin
                            state     <= ST_START;
                            core_init <= init_bit;
                            core_next <= ~init_bit;
                        end
                    end
                    ST_START: state <= ST_BUSY;
                    ST_BUSY: begin
                        if (tag_rise) begin
                            state   <= ST_CAPTURE;
                            capture <= 1'b1;
                        end
                    end
                    ST_CAPTURE: state <= ST_IDLE;
                    default:    state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/hmac_ctrl_wrapper.sv
// Register front-end for an HMAC-384/512 core: key/block/tag banks, status, interrupt, zeroize.
module hmac_ctrl_wrapper
    import hmac_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned KEY_WORDS   = 16,
    parameter int unsigned BLOCK_WORDS = 32,
    parameter int unsigned TAG_WORDS   = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cs,
    input  logic                        we,
    input  logic [ADDR_WIDTH-1:0]       address,
    input  logic [31:0]                 write_data,
    output logic [31:0]                 read_data,
    output logic                        core_init,
    output logic                        core_next,
    output logic                        core_mode,
    output logic                        core_zeroize,
    output logic [32*KEY_WORDS-1:0]     core_key,
    output logic [32*BLOCK_WORDS-1:0]   core_block,
    input  logic                        core_ready,
    input  logic [32*TAG_WORDS-1:0]     core_tag,
    input  logic                        core_tag_valid,
    output logic                        intr
);

    logic [31:0] key_q   [KEY_WORDS];
    logic [31:0] block_q [BLOCK_WORDS];
    logic [31:0] tag_q   [TAG_WORDS];

    logic ready_q, tag_valid_q;
    logic intr_en_q, done_q, err_cmd_q, err_wr_q;

    logic [31:0] addr32;
    logic        wr_c, rd_c, ctrl_wr_c, intr_wr_c, zeroize_c, idle_c;
    logic        key_hit_c, block_hit_c, tag_hit_c;
    logic [4:0]  key_idx_c, block_idx_c, tag_idx_c;
    logic        key_wr_c, block_wr_c, err_wr_set_c, tag_rise_c;
    fsm_state_e  state;
    logic        capture, accept_init_c, reject_c;
    status_t     status_c;

    // Bus decode
    assign addr32       = 32'(address);
    assign wr_c         = cs & we;
    assign rd_c         = cs & ~we;
    assign ctrl_wr_c    = wr_c & (addr32 == ADDR_CTRL);
    assign intr_wr_c    = wr_c & (addr32 == ADDR_INTR);
    assign zeroize_c    = ctrl_wr_c & write_data[CTRL_ZEROIZE_BIT];
    assign idle_c       = (state == ST_IDLE);
    assign key_hit_c    = in_window(addr32, ADDR_KEY_BASE, KEY_WORDS_MAX);
    assign block_hit_c  = in_window(addr32, ADDR_BLOCK_BASE, BLOCK_WORDS_MAX);
    assign tag_hit_c    = in_window(addr32, ADDR_TAG_BASE, TAG_WORDS_MAX);
    assign key_idx_c    = word_index(addr32, ADDR_KEY_BASE);
    assign block_idx_c  = word_index(addr32, ADDR_BLOCK_BASE);
    assign tag_idx_c    = word_index(addr32, ADDR_TAG_BASE);
    assign key_wr_c     = wr_c & key_hit_c & idle_c;
    assign block_wr_c   = wr_c & block_hit_c & idle_c;
    assign err_wr_set_c = wr_c & (key_hit_c | block_hit_c) & ~idle_c;
    assign tag_rise_c   = core_tag_valid & ~tag_valid_q;
    assign intr         = done_q & intr_en_q;

    hmac_ctrl_fsm u_fsm (
        .clk           (clk),
        .reset_n       (reset_n),
        .ctrl_wr       (ctrl_wr_c),
        .init_bit      (write_data[CTRL_INIT_BIT]),
        .next_bit      (write_data[CTRL_NEXT_BIT]),
        .zeroize_bit   (write_data[CTRL_ZEROIZE_BIT]),
        .ready_q       (ready_q),
        .tag_rise      (tag_rise_c),
        .state         (state),
        .core_init     (core_init),
        .core_next     (core_next),
        .capture       (capture),
        .accept_init_c (accept_init_c),
        .reject_c      (reject_c)
    );

    // Key bank: bus writes only while idle, cleared by zeroize
    always_ff @(posedge clk) begin
        if (!reset_n || zeroize_c) begin
            for (int unsigned i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
        end else if (key_wr_c) begin
            for (int unsigned i = 0; i < KEY_WORDS; i++)
                if (key_idx_c == 5'(i)) key_q[i] <= write_data;
        end
    end

    // Block bank: bus writes only while idle, cleared by zeroize
    always_ff @(posedge clk) begin
        if (!reset_n || zeroize_c) begin
            for (int unsigned i = 0; i < BLOCK_WORDS; i++) block_q[i] <= '0;
        end else if (block_wr_c) begin
            for (int unsigned i = 0; i < BLOCK_WORDS; i++)
                if (block_idx_c == 5'(i)) block_q[i] <= write_data;
        end
    end

    // Tag bank: loaded from the core on capture; HMAC-384 keeps only the first 12 words
    always_ff @(posedge clk) begin
        if (!reset_n || zeroize_c) begin
            for (int unsigned i = 0; i < TAG_WORDS; i++) tag_q[i] <= '0;
        end else if (capture) begin
            for (int unsigned i = 0; i < TAG_WORDS; i++)
                tag_q[i] <= (!core_mode && i >= TAG384_WORDS) ? 32'h0
                                                              : core_tag[32*(TAG_WORDS-1-i) +: 32];
        end
    end

    // Status, sticky bits, mode latch and zeroize pulse; a set wins over a same-cycle W1C
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ready_q      <= 1'b0;
            tag_valid_q  <= 1'b0;
            core_zeroize <= 1'b0;
            core_mode    <= 1'b0;
            intr_en_q    <= 1'b0;
            done_q       <= 1'b0;
            err_cmd_q    <= 1'b0;
            err_wr_q     <= 1'b0;
        end else begin
            ready_q      <= core_ready;
            tag_valid_q  <= core_tag_valid;
            core_zeroize <= zeroize_c;
            if (intr_wr_c) intr_en_q <= write_data[INTR_EN_BIT];
            if (zeroize_c) begin
                core_mode <= 1'b0;
                done_q    <= 1'b0;
                err_cmd_q <= 1'b0;
                err_wr_q  <= 1'b0;
            end else begin
                done_q    <= capture | (done_q & ~(intr_wr_c & write_data[INTR_DONE_BIT]));
                err_cmd_q <= reject_c | (err_cmd_q & ~(intr_wr_c & write_data[INTR_ERR_CMD_BIT]));
                err_wr_q  <= err_wr_set_c | (err_wr_q & ~(intr_wr_c & write_data[INTR_ERR_WR_BIT]));
                if (accept_init_c) core_mode <= write_data[CTRL_MODE_BIT];
            end
        end
    end

    // STATUS word assembly
    always_comb begin
        status_c           = '0;
        status_c.err_wr    = err_wr_q;
        status_c.err_cmd   = err_cmd_q;
        status_c.done      = done_q;
        status_c.tag_valid = tag_valid_q;
        status_c.ready     = ready_q;
    end

    // Read mux; tags are hidden while a command is in flight
    always_comb begin
        read_data = 32'h0;
        if (rd_c) begin
            case (addr32)
                ADDR_NAME0:    read_data = NAME0_VALUE;
                ADDR_NAME1:    read_data = NAME1_VALUE;
                ADDR_VERSION0: read_data = VERSION0_VALUE;
                ADDR_VERSION1: read_data = VERSION1_VALUE;
                ADDR_STATUS:   read_data = status_c;
                ADDR_INTR:     read_data = {28'h0, err_wr_q, err_cmd_q, done_q, intr_en_q};
                default:       read_data = 32'h0;
            endcase
            for (int unsigned i = 0; i < KEY_WORDS; i++)
                if (key_hit_c && key_idx_c == 5'(i)) read_data = key_q[i];
            for (int unsigned i = 0; i < BLOCK_WORDS; i++)
                if (block_hit_c && block_idx_c == 5'(i)) read_data = block_q[i];
            for (int unsigned i = 0; i < TAG_WORDS; i++)
                if (tag_hit_c && idle_c && tag_idx_c == 5'(i)) read_data = tag_q[i];
        end
    end

    // Flatten banks onto the core buses, word 0 in the MSBs
    always_comb begin
        core_key   = '0;
        core_block = '0;
        for (int unsigned i = 0; i < KEY_WORDS; i++)
            core_key[32*(KEY_WORDS-1-i) +: 32] = key_q[i];
        for (int unsigned i = 0; i < BLOCK_WORDS; i++)
            core_block[32*(BLOCK_WORDS-1-i) +: 32] = block_q[i];
    end

endmodule
